// File: rtl/rf_wb_pkg.sv
// Shared types and sizing helpers for the register-file writeback queue.
package rf_wb_pkg;

  localparam int unsigned WB_OPRAND_WIDTH  = 32;
  localparam int unsigned WB_REGNAME_WIDTH = 5;
  localparam int unsigned WB_DEPTH         = 8;

  typedef struct packed {
    logic [WB_REGNAME_WIDTH-1:0] addr;
    logic [WB_OPRAND_WIDTH-1:0]  data;
  } wb_entry_t;

  // Pointer width for a power-of-two queue depth; never narrower than one bit.
  function automatic int unsigned wb_ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_match_youngest.sv
// Youngest-first associative search over the valid queue entries.
module wb_match_youngest
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH      = WB_DEPTH,
  parameter int unsigned ADDR_WIDTH = WB_REGNAME_WIDTH,
  parameter int unsigned DATA_WIDTH = WB_OPRAND_WIDTH
) (
  input  logic [DEPTH-1:0]                 valid_i,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_i,
  input  logic [wb_ptr_width(DEPTH)-1:0]   tail_i,
  input  logic [ADDR_WIDTH-1:0]            look_addr_i,
  output logic                             hit_o,
  output logic [DATA_WIDTH-1:0]            data_o
);

  localparam int unsigned PtrW = wb_ptr_width(DEPTH);

  always_comb begin
    logic            found;
    logic [PtrW-1:0] idx;
    found  = 1'b0;
    idx    = '0;
    data_o = '0;
    // Walk backwards from the slot just before tail; the first match is the youngest.
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      idx = tail_i - PtrW'(k);
      if (!found && valid_i[idx] && (addr_i[idx] == look_addr_i)) begin
        found  = 1'b1;
        data_o = data_i[idx];
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue: accepts up to two results per cycle, drains up to two
// onto the register file write ports, and forwards the youngest queued value.
module rf_writeback_queue
  import rf_wb_pkg::*;
#(
  parameter int unsigned OPRAND_WIDTH  = WB_OPRAND_WIDTH,
  parameter int unsigned REGNAME_WIDTH = WB_REGNAME_WIDTH,
  parameter int unsigned DEPTH         = WB_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in1_valid_i,
  input  logic [REGNAME_WIDTH-1:0]     in1_addr_i,
  input  logic [OPRAND_WIDTH-1:0]      in1_data_i,
  input  logic                         in2_valid_i,
  input  logic [REGNAME_WIDTH-1:0]     in2_addr_i,
  input  logic [OPRAND_WIDTH-1:0]      in2_data_i,
  output logic                         in_ready_o,
  input  logic                         drain_en_i,
  input  logic                         flush_i,
  output logic                         write1_en_o,
  output logic [REGNAME_WIDTH-1:0]     write1_addr_o,
  output logic [OPRAND_WIDTH-1:0]      write1_data_o,
  output logic                         write2_en_o,
  output logic [REGNAME_WIDTH-1:0]     write2_addr_o,
  output logic [OPRAND_WIDTH-1:0]      write2_data_o,
  input  logic [REGNAME_WIDTH-1:0]     look_addr_i,
  output logic                         look_hit_o,
  output logic [OPRAND_WIDTH-1:0]      look_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = wb_ptr_width(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0]                       head_q, head_d, tail_q, tail_d;
  logic [PtrW-1:0]                       head_plus1, in2_slot;
  logic [CntW-1:0]                       count_q, count_d, count_after_pop;
  logic [DEPTH-1:0]                      valid_q, valid_d;
  logic [DEPTH-1:0][REGNAME_WIDTH-1:0]   addr_q;
  logic [DEPTH-1:0][OPRAND_WIDTH-1:0]    data_q;
  logic                                  drain1, drain2, same_addr;
  logic                                  push1, push2;
  logic [1:0]                            pops, pushes;

  // Drain selection and acceptance; both depend only on registered state and inputs.
  always_comb begin
    head_plus1      = head_q + PtrW'(1);
    drain1          = drain_en_i && (count_q != '0);
    drain2          = drain_en_i && (count_q >= CntW'(2));
    same_addr       = drain2 && (addr_q[head_q] == addr_q[head_plus1]);
    pops            = drain2 ? 2'd2 : (drain1 ? 2'd1 : 2'd0);
    count_after_pop = count_q - CntW'(pops);
    in_ready_o      = (count_after_pop <= CntW'(DEPTH - 2));
    push1           = in_ready_o && in1_valid_i && !flush_i;
    push2           = in_ready_o && in2_valid_i && !flush_i;
    in2_slot        = push1 ? (tail_q + PtrW'(1)) : tail_q;
    pushes          = {1'b0, push1} + {1'b0, push2};
  end

  // A same-address pair collapses to the younger write on port 2.
  always_comb begin
    write1_en_o   = drain1 && !same_addr;
    write2_en_o   = drain2;
    write1_addr_o = '0;
    write1_data_o = '0;
    write2_addr_o = '0;
    write2_data_o = '0;
    if (write1_en_o) begin
      write1_addr_o = addr_q[head_q];
      write1_data_o = data_q[head_q];
    end
    if (write2_en_o) begin
      write2_addr_o = addr_q[head_plus1];
      write2_data_o = data_q[head_plus1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q + PtrW'(pops);
    tail_d  = tail_q + PtrW'(pushes);
    count_d = count_q + CntW'(pushes) - CntW'(pops);
    if (drain1) valid_d[head_q] = 1'b0;
    if (drain2) valid_d[head_plus1] = 1'b0;
    // Sets after clears: a full queue draining two may refill the slot it just freed.
    if (push1) valid_d[tail_q] = 1'b1;
    if (push2) valid_d[in2_slot] = 1'b1;
    if (flush_i) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage carries no reset; valid_q qualifies every use.
  always_ff @(posedge clk) begin
    if (push1) begin
      addr_q[tail_q] <= in1_addr_i;
      data_q[tail_q] <= in1_data_i;
    end
    if (push2) begin
      addr_q[in2_slot] <= in2_addr_i;
      data_q[in2_slot] <= in2_data_i;
    end
  end

  wb_match_youngest #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (REGNAME_WIDTH),
    .DATA_WIDTH (OPRAND_WIDTH)
  ) u_look (
    .valid_i     (valid_q),
    .addr_i      (addr_q),
    .data_i      (data_q),
    .tail_i      (tail_q),
    .look_addr_i (look_addr_i),
    .hit_o       (look_hit_o),
    .data_o      (look_data_o)
  );

  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Write-side client of the 2-read/2-write register file.
- Buffers completed results from up to two execution units per cycle in an in-order circular queue.
- Drains up to two entries per cycle onto the register file's write1/write2 ports.
- Exposes a youngest-match forwarding lookup so operand reads see results still waiting in the queue.

Parameters:
OPRAND_WIDTH, 32, data width of one result
REGNAME_WIDTH, 5, register address width
DEPTH, 8, queue entries; power of two, at least 4

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
in1_valid_i  input  1  result 1 present (older of the pair)
in1_addr_i  input  REGNAME_WIDTH  result 1 destination
in1_data_i  input  OPRAND_WIDTH  result 1 value
in2_valid_i  input  1  result 2 present (younger)
in2_addr_i  input  REGNAME_WIDTH  result 2 destination
in2_data_i  input  OPRAND_WIDTH  result 2 value
in_ready_o  output  1  queue accepts inputs this cycle
drain_en_i  input  1  register file may be written this cycle
flush_i  input  1  synchronous discard of all entries
write1_en_o  output  1  to register file write1_en_i
write1_addr_o  output  REGNAME_WIDTH  to write1_addr_i
write1_data_o  output  OPRAND_WIDTH  to write1_data_i
write2_en_o  output  1  to register file write2_en_i
write2_addr_o  output  REGNAME_WIDTH  to write2_addr_i
write2_data_o  output  OPRAND_WIDTH  to write2_data_i
look_addr_i  input  REGNAME_WIDTH  forwarding lookup address
look_hit_o  output  1  a queued entry targets look_addr_i
look_data_o  output  OPRAND_WIDTH  data of the youngest matching entry
count_o  output  $clog2(DEPTH+1)  occupied entries
empty_o  output  1  count_o == 0

Behaviour:
- Reset (rst low, asynchronous): head=0, tail=0, count=0, all entry valid bits 0. Outputs: write*_en_o=0, look_hit_o=0, count_o=0, empty_o=1, in_ready_o=1. Entry data/addr are not reset. Address and data outputs read 0 while their enable is 0.
- in_ready_o = (count - pops_this_cycle) <= DEPTH-2. Combinational. Uses the current cycle's drain, so a full queue that is draining two entries accepts two new ones in the same cycle.
- Enqueue happens when in_ready_o && inX_valid_i.
  - in1 is written at tail, in2 at the next free slot.
  - If only in2 is valid, it takes tail.
  - Valid inputs presented while in_ready_o=0 are ignored. Producers hold them.
- Drain is combinational from the registered queue state; an entry enqueued at edge N is written at the earliest during cycle N+1. Only when drain_en_i=1:
  - count>=1: write1 drives head.
  - count>=2: write2 drives head+1.
  - Pop count is 0, 1 or 2 and takes effect at the clock edge.
- Same-address pair: when both drain entries share an address, write1_en_o=0, write2_en_o=1 and both entries are popped. The younger value wins. The register file never sees two writes to one entry in one cycle.
- drain_en_i=0: both write enables are 0 and nothing is popped. Enqueue continues normally.
- Pointers wrap modulo DEPTH. count_next = count + pushes - pops, never above DEPTH and never below 0.
- Lookup is combinational over valid entries. look_hit_o=1 if any entry address equals look_addr_i. look_data_o is the data of the youngest match (nearest to tail), otherwise 0. Entries draining in the current cycle still count as hits.
- flush_i=1: at the next edge count=0, head=tail=0 and all valid bits clear. Same-cycle enqueues are discarded. Write enables stay live during the flush cycle if drain_en_i=1.
- Reset asserted mid-operation: all queued entries are lost and the reset values are forced immediately.

Decomposition:
- Package rf_wb_pkg: typedef wb_entry_t {addr, data}; constant for DEPTH pointer width.
- Sub-module wb_match_youngest: priority search from tail back to head, producing hit and data for the lookup. It is instantiated once and is reusable for a second lookup port later.

Test Plan:
- Reset, then in1=(addr 3, 0xAAAA) with drain_en=1 -> the following cycle write1_en=1, addr 3, data 0xAAAA, write2_en=0; count returns to 0.
- drain_en=0 while pushing four pairs -> count=8, in_ready_o=0, a fifth pair is ignored; drain_en=1 -> pairs emerge two per cycle in order, with in_ready_o=1 in the first draining cycle.
- Queue holds (5,0x11) then (5,0x22) at head, drain_en=1 -> write1_en=0, write2_en=1 addr 5 data 0x22; count drops by 2.
- Queue holds (7,0x1),(2,0x9),(7,0x3), look_addr=7 -> look_hit=1, look_data=0x3; look_addr=4 -> look_hit=0, data 0.
- Pointer wrap: run 20 single pushes and pops with DEPTH=8 -> output order matches input order; count never exceeds 8.
- Assert flush_i with count=5 -> count_o=0 and empty_o=1 next cycle. Drop rst mid-drain -> all enables 0 immediately, count_o=0.
